// File: rtl/ram_latency_model.sv
// Word-addressed RAM behind a fixed-latency FREE/BUSY/ACCESS handshake.
// Define RAM_ERR_CHECK_EN to report ERROR for illegal requests.
module ram_latency_model #(
  parameter int LATENCY   = 2,
  parameter int ADDR_BITS = 14,
  parameter int CNT_W     = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ramREN,
  input  logic        ramWEN,
  input  logic [31:0] ramaddr,
  input  logic [31:0] ramstore,
  output logic [31:0] ramload,
  output logic [1:0]  ramstate,
  output logic [31:0] access_count,
  output logic [1:0]  st_dbg
);
  // Handshake: the controller holds REN/WEN, address and store data stable
  // until ramstate shows ACCESS for one cycle; any change before that aborts
  // the pending access and the changed request starts a fresh full latency.
  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} st_t;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  st_t                  st;
  logic [CNT_W-1:0]     cnt;
  logic [32:0]          key_q;
  logic [31:0]          mem [2**ADDR_BITS];

  logic                 req;
  logic                 match;
  logic                 err;
  logic                 commit;
  logic [32:0]          key;
  logic [ADDR_BITS-1:0] idx;

  assign req   = ramREN | ramWEN;
  assign key   = {ramaddr, ramWEN};
  assign idx   = ramaddr[ADDR_BITS+1:2];
  assign match = req && (key == key_q);

`ifdef RAM_ERR_CHECK_EN
  assign err = req && ((ramREN && ramWEN) || (ramaddr[1:0] != 2'b00) ||
                       (ramaddr[31:ADDR_BITS+2] != '0));
`else
  logic unused_addr;
  assign unused_addr = ^{ramaddr[1:0], ramaddr[31:ADDR_BITS+2]};
  assign err = 1'b0;
`endif

  assign commit = (st == DONE) && match && !err;
  assign st_dbg = st;

  // Reset forces FREE even while the controller still holds a request.
  always_comb begin
    ramstate = FREE;
    if (RST || !req)          ramstate = FREE;
    else if (err)             ramstate = ERROR;
    else if (st == DONE && match) ramstate = ACCESS;
    else                      ramstate = BUSY;
  end

  assign ramload = (ramstate == ACCESS && ramREN) ? mem[idx] : 32'd0;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      st           <= IDLE;
      cnt          <= '0;
      key_q        <= '0;
      access_count <= '0;
    end else if (!req || err) begin
      st <= IDLE;
    end else if ((st == WAIT || st == DONE) && match) begin
      if (st == DONE) begin
        st           <= IDLE;
        access_count <= access_count + 32'd1;
      end else begin
        cnt <= cnt - 1'b1;
        if (cnt == CNT_W'(1)) st <= DONE;
      end
    end else begin
      // New request, or a changed key that replaces the pending one.
      key_q <= key;
      cnt   <= CNT_LOAD;
      st    <= (LATENCY == 1) ? DONE : WAIT;
    end
  end

  always_ff @(posedge CLK) begin
    if (commit && ramWEN) mem[idx] <= ramstore;
  end

endmodule

// File: tb/tb_ram_latency_model.sv
// Bench for ram_latency_model: directed vector table, reset/abort sequences,
// and randomized traffic against a run-length access model.
module tb_ram_latency_model;
  localparam int LAT = 2;
  localparam int AB  = 14;
  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        ramREN = 1'b0;
  logic        ramWEN = 1'b0;
  logic [31:0] ramaddr = 32'd0;
  logic [31:0] ramstore = 32'd0;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  logic [31:0] access_count;
  logic [1:0]  st_dbg;

  always #5 CLK = ~CLK;

  ram_latency_model #(.LATENCY(LAT), .ADDR_BITS(AB), .CNT_W(4)) dut (
    .CLK(CLK), .RST(RST), .ramREN(ramREN), .ramWEN(ramWEN),
    .ramaddr(ramaddr), .ramstore(ramstore), .ramload(ramload),
    .ramstate(ramstate), .access_count(access_count), .st_dbg(st_dbg)
  );

  typedef struct {
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  exp_state;
    logic [31:0] exp_load;
  } vec_t;

  vec_t        vecs[$];
  logic [33:0] exp_q[$];
  logic [31:0] model_mem [int];
  logic [32:0] run_key;
  int          run_len = 0;
  int          model_count = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic ren, input logic wen, input logic [31:0] addr,
                       input logic [31:0] data);
    ramREN = ren; ramWEN = wen; ramaddr = addr; ramstore = data;
  endtask

  task automatic add(input logic ren, input logic wen, input logic [31:0] addr,
                     input logic [31:0] data, input logic [1:0] es, input logic [31:0] el);
    vec_t v;
    v.ren = ren; v.wen = wen; v.addr = addr; v.data = data;
    v.exp_state = es; v.exp_load = el;
    vecs.push_back(v);
  endtask

  task automatic run_one(input string nm, input logic ren, input logic wen,
                         input logic [31:0] addr, input logic [31:0] data,
                         input logic [1:0] es, input logic [31:0] el);
    drive(ren, wen, addr, data);
    @(negedge CLK);
    check({nm, " state"}, 32'(ramstate), 32'(es));
    check({nm, " load"}, ramload, el);
    tick();
  endtask

  // An access completes on the (LAT+1)-th consecutive cycle of an unchanged
  // request key; the cycle after a completion always starts a new access.
  task automatic model_step();
    logic [32:0] k;
    logic [1:0]  s;
    logic [31:0] ld;
    int          widx;
    k    = {ramaddr, ramWEN};
    ld   = 32'd0;
    widx = int'(ramaddr[AB+1:2]);
    if (!(ramREN || ramWEN)) begin
      s = FREE; run_len = 0;
    end else if (run_len > 0 && k == run_key && run_len == LAT) begin
      s = ACCESS;
      if (ramREN) ld = model_mem.exists(widx) ? model_mem[widx] : 32'd0;
      if (ramWEN) model_mem[widx] = ramstore;
      model_count++;
      run_len = 0;
    end else if (run_len > 0 && k == run_key) begin
      s = BUSY; run_len++;
    end else begin
      s = BUSY; run_key = k; run_len = 1;
    end
    exp_q.push_back({s, ld});
  endtask

  task automatic rand_cycle(input int c);
    logic [33:0] e;
    @(negedge CLK);
    check($sformatf("rnd%0d count", c), access_count, 32'(model_count));
    model_step();
    e = exp_q.pop_front();
    check($sformatf("rnd%0d state", c), 32'(ramstate), 32'(e[33:32]));
    check($sformatf("rnd%0d load", c), ramload, e[31:0]);
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Preload 0x40, then the main vector table (state and load per cycle).
    add(0, 1, 32'h40, 32'h12345678, BUSY, 0);
    add(0, 1, 32'h40, 32'h12345678, BUSY, 0);
    add(0, 1, 32'h40, 32'h12345678, ACCESS, 0);
    add(0, 0, 32'h0, 32'h0, FREE, 0);
    add(1, 0, 32'h40, 0, BUSY, 0);
    add(1, 0, 32'h40, 0, BUSY, 0);
    add(1, 0, 32'h40, 0, ACCESS, 32'h12345678);
    add(0, 0, 32'h0, 0, FREE, 0);
    add(0, 1, 32'h80, 32'hDEADBEEF, BUSY, 0);
    add(0, 1, 32'h80, 32'hDEADBEEF, BUSY, 0);
    add(0, 1, 32'h80, 32'hDEADBEEF, ACCESS, 0);
    add(1, 0, 32'h80, 0, BUSY, 0);
    add(1, 0, 32'h80, 0, BUSY, 0);
    add(1, 0, 32'h80, 0, ACCESS, 32'hDEADBEEF);
    add(0, 0, 32'h0, 0, FREE, 0);
    add(0, 1, 32'h100, 32'h11111111, BUSY, 0);
    add(0, 1, 32'h100, 32'h11111111, BUSY, 0);
    add(0, 1, 32'h100, 32'h11111111, ACCESS, 0);
    add(0, 1, 32'h104, 32'h22222222, BUSY, 0);
    add(0, 1, 32'h104, 32'h22222222, BUSY, 0);
    add(0, 1, 32'h104, 32'h22222222, ACCESS, 0);
    add(1, 0, 32'h100, 0, BUSY, 0);
    add(1, 0, 32'h100, 0, BUSY, 0);
    add(1, 0, 32'h100, 0, ACCESS, 32'h11111111);
    add(1, 0, 32'h104, 0, BUSY, 0);
    add(1, 0, 32'h104, 0, BUSY, 0);
    add(1, 0, 32'h104, 0, ACCESS, 32'h22222222);
    add(0, 0, 32'h0, 0, FREE, 0);
    add(0, 1, 32'h24, 32'hA5A5A5A5, BUSY, 0);
    add(0, 1, 32'h24, 32'hA5A5A5A5, BUSY, 0);
    add(0, 1, 32'h24, 32'hA5A5A5A5, ACCESS, 0);
    add(0, 0, 32'h0, 0, FREE, 0);
    add(1, 0, 32'h20, 0, BUSY, 0);
    add(1, 0, 32'h24, 0, BUSY, 0);
    add(1, 0, 32'h24, 0, BUSY, 0);
    add(1, 0, 32'h24, 0, ACCESS, 32'hA5A5A5A5);
    add(0, 0, 32'h0, 0, FREE, 0);
    add(0, 1, 32'h40, 32'h0BAD0BAD, BUSY, 0);
    add(0, 1, 32'h40, 32'h0BAD0BAD, BUSY, 0);
    add(0, 0, 32'h0, 0, FREE, 0);
    add(1, 0, 32'h40, 0, BUSY, 0);
    add(1, 0, 32'h40, 0, BUSY, 0);
    add(1, 0, 32'h40, 0, ACCESS, 32'h12345678);
    add(0, 0, 32'h0, 0, FREE, 0);

    // Reset state.
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("reset state", 32'(ramstate), 32'(FREE));
    check("reset load", ramload, 32'd0);
    check("reset count", access_count, 32'd0);
    RST = 1'b0;
    tick();

    for (int i = 0; i < 4; i++)
      run_one($sformatf("vec%0d", i), vecs[i].ren, vecs[i].wen, vecs[i].addr,
              vecs[i].data, vecs[i].exp_state, vecs[i].exp_load);

    RST = 1'b1;
    #1;
    check("pulse count", access_count, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    tick();

    for (int i = 4; i < vecs.size(); i++)
      run_one($sformatf("vec%0d", i), vecs[i].ren, vecs[i].wen, vecs[i].addr,
              vecs[i].data, vecs[i].exp_state, vecs[i].exp_load);
    check("table count", access_count, 32'd10);

    // Reset in the second BUSY cycle of a write loses the write.
    run_one("t5 pre", 0, 1, 32'h200, 32'h600DF00D, BUSY, 0);
    run_one("t5 pre", 0, 1, 32'h200, 32'h600DF00D, BUSY, 0);
    run_one("t5 pre", 0, 1, 32'h200, 32'h600DF00D, ACCESS, 0);
    run_one("t5 idle", 0, 0, 32'h0, 0, FREE, 0);
    check("t5 count before", access_count, 32'd11);
    run_one("t5 w0", 0, 1, 32'h200, 32'hCAFEF00D, BUSY, 0);
    @(negedge CLK);
    check("t5 w1 state", 32'(ramstate), 32'(BUSY));
    RST = 1'b1;
    #1;
    check("t5 rst state", 32'(ramstate), 32'(FREE));
    check("t5 rst count", access_count, 32'd0);
    drive(0, 0, 32'h0, 32'h0);
    tick();
    @(negedge CLK);
    RST = 1'b0;
    tick();
    run_one("t5 rd", 1, 0, 32'h200, 0, BUSY, 0);
    run_one("t5 rd", 1, 0, 32'h200, 0, BUSY, 0);
    run_one("t5 rd", 1, 0, 32'h200, 0, ACCESS, 32'h600DF00D);
    run_one("t5 idle2", 0, 0, 32'h0, 0, FREE, 0);
    check("t5 count after", access_count, 32'd1);

`ifdef RAM_ERR_CHECK_EN
    run_one("err both", 1, 1, 32'h0, 32'h1, ERROR, 0);
    run_one("err both", 1, 1, 32'h0, 32'h1, ERROR, 0);
    run_one("err low", 1, 0, 32'h3, 0, ERROR, 0);
    for (int i = 0; i < LAT + 2; i++)
      run_one("err high", 0, 1, 32'h10040, 32'h00000BAD, ERROR, 0);
    run_one("err idle", 0, 0, 32'h0, 0, FREE, 0);
    check("err count", access_count, 32'd1);
    run_one("err rd", 1, 0, 32'h40, 0, BUSY, 0);
    run_one("err rd", 1, 0, 32'h40, 0, BUSY, 0);
    run_one("err rd", 1, 0, 32'h40, 0, ACCESS, 32'h12345678);
    run_one("err idle2", 0, 0, 32'h0, 0, FREE, 0);
    model_count = 2;
`else
    model_count = 1;
`endif

    // Random traffic over eight preloaded words at 0x300.
    run_len = 0;
    for (int w = 0; w < 8; w++) begin
      drive(0, 1, 32'h300 + 32'(4 * w), $urandom);
      repeat (LAT + 1) rand_cycle(w);
      drive(0, 0, 32'h0, 32'h0);
      rand_cycle(w);
    end
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 99) >= 70) begin
        int op;
`ifdef RAM_ERR_CHECK_EN
        op = $urandom_range(0, 2);
`else
        op = $urandom_range(0, 3);
`endif
        drive(op == 1 || op == 3, op >= 2,
              32'h300 + 32'(4 * $urandom_range(0, 7)), $urandom);
      end
      rand_cycle(100 + c);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
